// File: rtl/rom_load_seq.sv
// ROM download sequencer: routes the HPS ioctl byte stream to one-hot ROM regions
// and holds the game core in reset across loads and reset requests.
module rom_load_seq #(
    parameter logic [7:0]  IDX  = 8'd0,
    parameter logic [24:0] END0 = 25'h0C000,
    parameter logic [24:0] END1 = 25'h0E000,
    parameter logic [24:0] END2 = 25'h1A000,
    parameter logic [24:0] END3 = 25'h2A000,
    parameter logic [15:0] HOLD = 16'd1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    input  logic        rst_req,
    output logic [24:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_we,
    output logic [3:0]  rom_sel,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_short,
    output logic        load_ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_t;

    state_t      state_q;
    logic        dl_q;
    logic [15:0] hcnt_q;
    logic [24:0] bcnt_q, bcnt_d;
    logic [24:0] rom_addr_q;
    logic [7:0]  rom_data_q;
    logic        rom_we_q;
    logic [3:0]  rom_sel_q, sel_d;
    logic        core_reset_q;
    logic        load_ok_q, load_short_q, load_ovf_q, ovf_d;

    logic idx_ok, dl_rise, dl_fall, wr_hit, in_rng, hold_done;

    assign idx_ok    = (ioctl_index == IDX);
    assign dl_rise   = ioctl_download & ~dl_q & idx_ok;
    assign dl_fall   = ~ioctl_download & dl_q;
    assign wr_hit    = (state_q == S_LOAD) & ioctl_wr & idx_ok;
    assign in_rng    = (ioctl_addr < END3);
    assign hold_done = ({1'b0, hcnt_q} + 17'd1) >= {1'b0, HOLD};
    assign ovf_d     = load_ovf_q | (wr_hit & ~in_rng);

    always_comb begin
        bcnt_d = bcnt_q;
        if (wr_hit && in_rng && (bcnt_q < END3))
            bcnt_d = bcnt_q + 25'd1;
    end

    always_comb begin
        sel_d = 4'b0000;
        unique case (1'b1)
            (ioctl_addr < END0):                        sel_d = 4'b0001;
            (ioctl_addr >= END0 && ioctl_addr < END1):  sel_d = 4'b0010;
            (ioctl_addr >= END1 && ioctl_addr < END2):  sel_d = 4'b0100;
            (ioctl_addr >= END2 && ioctl_addr < END3):  sel_d = 4'b1000;
            default:                                    sel_d = 4'b0000;
        endcase
    end

    // dl_q resets high so a stream still running across reset needs a fresh rise
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            dl_q         <= 1'b1;
            hcnt_q       <= '0;
            bcnt_q       <= '0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            rom_we_q     <= 1'b0;
            rom_sel_q    <= 4'b0000;
            core_reset_q <= 1'b1;
            load_ok_q    <= 1'b0;
            load_short_q <= 1'b0;
            load_ovf_q   <= 1'b0;
        end else begin
            dl_q     <= ioctl_download;
            rom_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (dl_rise) begin
                        state_q      <= S_LOAD;
                        core_reset_q <= 1'b1;
                        bcnt_q       <= '0;
                        load_ok_q    <= 1'b0;
                        load_short_q <= 1'b0;
                        load_ovf_q   <= 1'b0;
                    end else if (rst_req) begin
                        hcnt_q <= '0;
                    end else if (hold_done) begin
                        state_q      <= S_RUN;
                        core_reset_q <= 1'b0;
                        hcnt_q       <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + 16'd1;
                    end
                end
                S_RUN: begin
                    if (dl_rise) begin
                        state_q      <= S_LOAD;
                        core_reset_q <= 1'b1;
                        bcnt_q       <= '0;
                        load_ok_q    <= 1'b0;
                        load_short_q <= 1'b0;
                        load_ovf_q   <= 1'b0;
                    end else if (rst_req) begin
                        state_q      <= S_HOLD;
                        core_reset_q <= 1'b1;
                        hcnt_q       <= '0;
                    end
                end
                S_LOAD: begin
                    if (wr_hit) begin
                        if (in_rng) begin
                            rom_we_q   <= 1'b1;
                            rom_addr_q <= ioctl_addr;
                            rom_data_q <= ioctl_dout;
                            rom_sel_q  <= sel_d;
                        end else begin
                            rom_sel_q <= 4'b0000;
                        end
                    end
                    bcnt_q     <= bcnt_d;
                    load_ovf_q <= ovf_d;
                    // status uses this cycle's write so a write on the fall edge counts
                    if (dl_fall) begin
                        state_q      <= S_HOLD;
                        hcnt_q       <= '0;
                        load_ok_q    <= (bcnt_d == END3) && !ovf_d;
                        load_short_q <= (bcnt_d < END3);
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_reset_q <= 1'b1;
                    hcnt_q       <= '0;
                end
            endcase
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign rom_we     = rom_we_q;
    assign rom_sel    = rom_sel_q;
    assign core_reset = core_reset_q;
    assign load_ok    = load_ok_q;
    assign load_short = load_short_q;
    assign load_ovf   = load_ovf_q;

endmodule
